// File: rtl/simon_phase_ctrl_if.sv
// Go/done handshake bundle between the Simon phase sequencer and its phase blocks.
// The master side issues one-cycle go strobes. Each slave returns a done pulse, and the compare block also returns its result.
interface simon_phase_ctrl_if;
  logic gen_go;
  logic gen_done;
  logic disp_go;
  logic disp_done;
  logic wait_go;
  logic wait_done;
  logic chk_go;
  logic chk_done;
  logic chk_pass;

  modport master (
    output gen_go, disp_go, wait_go, chk_go,
    input  gen_done, disp_done, wait_done, chk_done, chk_pass
  );

  modport slave (
    input  gen_go, disp_go, wait_go, chk_go,
    output gen_done, disp_done, wait_done, chk_done, chk_pass
  );
endinterface

// File: rtl/simon_phase_ctrl.sv
// Simon game sequencer: IDLE -> GEN -> DISP -> WAIT -> CHK, looping DISP..CHK per round until WIN or LOSE.
// Optional WAIT-phase watchdog is enabled by defining PHASE_TIMEOUT_EN.
module simon_phase_ctrl #(
  parameter int          MAX_ROUNDS     = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  simon_phase_ctrl_if.master        ph,
  output logic [3:0]                round,
  output logic [2:0]                phase,
  output logic                      win,
  output logic                      lose,
  output logic                      timeout
);

  if (MAX_ROUNDS < 1 || MAX_ROUNDS > 16) begin : g_bad_max_rounds
    $error("simon_phase_ctrl: MAX_ROUNDS must be in 1..16");
  end
  if (TIMEOUT_CYCLES == 24'd0) begin : g_bad_timeout
    $error("simon_phase_ctrl: TIMEOUT_CYCLES must be non-zero");
  end

  localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GEN  = 3'd1,
    S_DISP = 3'd2,
    S_WAIT = 3'd3,
    S_CHK  = 3'd4,
    S_WIN  = 3'd5,
    S_LOSE = 3'd6
  } state_t;

  state_t     state, state_n;
  logic [3:0] round_n;
  logic       start_q;
  logic       start_edge_q;
  logic       tmo_hit;
  logic       gen_go_q, disp_go_q, wait_go_q, chk_go_q;

  // The start edge is registered so that the GEN entry lands two edges after start rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q      <= 1'b0;
      start_edge_q <= 1'b0;
    end else begin
      start_q      <= start;
      start_edge_q <= start & ~start_q;
    end
  end

`ifdef PHASE_TIMEOUT_EN
  logic [23:0] wait_cnt;

  // The counter is cleared on entry, so it reads 0 during the wait_go cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 24'd0;
    end else if (state_n == S_WAIT && state != S_WAIT) begin
      wait_cnt <= 24'd0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 24'd1;
    end
  end

  assign tmo_hit = (wait_cnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (state == S_WAIT && state_n == S_LOSE) begin
      timeout <= 1'b1;
    end else if (state_n == S_GEN && (state == S_WIN || state == S_LOSE)) begin
      timeout <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      round <= 4'd0;
    end else begin
      state <= state_n;
      round <= round_n;
    end
  end

  // A done pulse is ignored while its go is still high, which is the first cycle of the phase.
  always_comb begin
    state_n = state;
    round_n = round;
    case (state)
      S_IDLE: begin
        if (start_edge_q) begin
          state_n = S_GEN;
          round_n = 4'd0;
        end
      end
      S_GEN: begin
        if (ph.gen_done && !gen_go_q) state_n = S_DISP;
      end
      S_DISP: begin
        if (ph.disp_done && !disp_go_q) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (ph.wait_done && !wait_go_q) begin
          state_n = S_CHK;
        end else if (tmo_hit) begin
          state_n = S_LOSE;
        end
      end
      S_CHK: begin
        if (ph.chk_done && !chk_go_q) begin
          if (!ph.chk_pass) begin
            state_n = S_LOSE;
          end else if (round == LAST_ROUND) begin
            state_n = S_WIN;
          end else begin
            state_n = S_DISP;
            round_n = round + 4'd1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (start_edge_q) begin
          state_n = S_GEN;
          round_n = 4'd0;
        end
      end
      default: begin
        state_n = S_IDLE;
        round_n = 4'd0;
      end
    endcase
  end

  // Go strobes and status flags are registered alongside the state, so they line up with phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_go_q  <= 1'b0;
      disp_go_q <= 1'b0;
      wait_go_q <= 1'b0;
      chk_go_q  <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      gen_go_q  <= (state_n == S_GEN)  && (state != S_GEN);
      disp_go_q <= (state_n == S_DISP) && (state != S_DISP);
      wait_go_q <= (state_n == S_WAIT) && (state != S_WAIT);
      chk_go_q  <= (state_n == S_CHK)  && (state != S_CHK);
      win       <= (state_n == S_WIN);
      lose      <= (state_n == S_LOSE);
    end
  end

  assign ph.gen_go  = gen_go_q;
  assign ph.disp_go = disp_go_q;
  assign ph.wait_go = wait_go_q;
  assign ph.chk_go  = chk_go_q;
  assign phase      = state;

endmodule
